cdb_arb: RTL and testbench
==========================

Name: cdb_arb

Overview:
- Arbitrates the single common data bus between the execution units (alu, mdu, lsu, jmp). Each unit offers one completed result per cycle.
- Grants at most one result per cycle and registers it onto the broadcast bus read by the rob and all reservation stations.
- Priority is round-robin, with a starvation override so a long-blocked unit (e.g. mdu behind a stream of alu ops) is guaranteed service.

Parameters:
- N_REQ, 4, number of requesting execution units; index 0=alu, 1=mdu, 2=lsu, 3=jmp.
- TAG_W, 5, reservation-station tag width.
- ROB_PTR_W, 4, rob index width.
- MAX_WAIT, 3, consecutive blocked cycles after which a requester becomes starved.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  pipeline flush from rob, synchronous.
- req_valid  in  N_REQ  per-unit result valid.
- req_ready  out  N_REQ  per-unit grant, combinational from current state and req_valid.
- req_tag  in  N_REQ*TAG_W  packed tags, unit i at slice [i*TAG_W +: TAG_W].
- req_rob_id  in  N_REQ*ROB_PTR_W  packed rob indices.
- req_data  in  N_REQ*32  packed result data.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_rob_id  out  ROB_PTR_W  broadcast rob index.
- cdb_data  out  32  broadcast data.
- cdb_src  out  N_REQ  one-hot source of the current broadcast.

Behaviour:
- Reset (async, rst=1): cdb_valid=0, cdb_tag=0, cdb_rob_id=0, cdb_data=0, cdb_src=0, rr_ptr=0, all wait counters=0.
- Handshake: a transfer occurs on req_valid[i] & req_ready[i].
  - Requester must hold valid and payload stable until ready.
  - A requester may drop valid only during flush.
- At most one bit of req_ready is set per cycle; req_ready[i]=0 whenever req_valid[i]=0.
- Wait counters: wait[i] is WAIT_W=$clog2(MAX_WAIT+1) bits.
  - Increments, saturating at MAX_WAIT, when req_valid[i] & !req_ready[i].
  - Clears when granted or when req_valid[i]=0.
- Starved set: requesters with wait[i]==MAX_WAIT and req_valid[i]=1.
- Winner selection:
  - If the starved set is non-empty, the lowest-index starved requester wins.
  - Else round-robin: the first valid requester searching rr_ptr, rr_ptr+1, ... mod N_REQ.
- rr_ptr update: on any grant, rr_ptr <= (winner+1) mod N_REQ, including starvation grants. With no grant, rr_ptr holds.
- Latency: a result granted in cycle t appears on cdb_* in cycle t+1, with cdb_valid=1 for exactly one cycle per transfer.
  - No grant in cycle t gives cdb_valid=0 in t+1. Payload fields then hold their previous values; only cdb_valid is meaningful.
- Throughput: one broadcast per cycle; back-to-back grants to the same unit are allowed when it is the only valid requester.
- Flush (flush=1 in cycle t):
  - req_ready=0 in cycle t.
  - cdb_valid=0, cdb_src=0 in t+1.
  - Wait counters clear and rr_ptr resets to 0 in t+1.
  - A result registered in cycle t-1 is still broadcast during t.
- Reset mid-transfer: the pending broadcast is dropped immediately (async).

Decomposition:
- Shared core package: EXU index constants (EXU_ALU=0, EXU_MDU=1, EXU_LSU=2, EXU_JMP=3), N_EXU=4, and a cdb_pkt_t struct {tag, rob_id, data}.
- One sub-module: rr_pick, a combinational rotate-priority encoder (inputs req vector and start pointer; outputs one-hot grant and any-grant). It is reused for the starved-set search with pointer 0.

Test Plan:
- Single requester: after reset, alu valid with tag=5, rob=3, data=0xDEADBEEF → req_ready[0]=1 same cycle; next cycle cdb_valid=1, tag=5, rob_id=3, data=0xDEADBEEF, src=0001.
- Round-robin: all four valid continuously from rr_ptr=0 → grant order 0,1,2,3,0 on consecutive cycles; cdb_src 0001,0010,0100,1000,0001.
- Starvation: alu granted continuously by forcing rr_ptr to favour it while mdu is held valid → by the 4th blocked cycle (wait=3) mdu wins; alu wait count is then 1.
- Simultaneous starved: units 1 and 3 both at wait=3 → unit 1 granted, then unit 3 next cycle, regardless of rr_ptr.
- Flush: grant in cycle t-1, flush in t with all valid → broadcast from t-1 appears in t; req_ready=0 in t; cdb_valid=0 in t+1; rr_ptr=0 afterwards.
- Async reset asserted mid-stream between clock edges → cdb_valid drops to 0 immediately, before the next edge; first grant after release goes to unit 0.

Source files
------------

// File: rtl/cdb_arb_pkg.sv
// Shared definitions for the common data bus arbiter: execution-unit indices
// and the broadcast packet layout.
package cdb_arb_pkg;

  localparam int N_EXU   = 4;
  localparam int EXU_ALU = 0;
  localparam int EXU_MDU = 1;
  localparam int EXU_LSU = 2;
  localparam int EXU_JMP = 3;

  localparam int CDB_TAG_W     = 5;
  localparam int CDB_ROB_PTR_W = 4;
  localparam int CDB_DATA_W    = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]     tag;
    logic [CDB_ROB_PTR_W-1:0] rob_id;
    logic [CDB_DATA_W-1:0]    data;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arb_rr_pick.sv
// Rotating-priority encoder: picks the first set request at or after the
// start pointer, wrapping modulo N. Purely combinational.
module cdb_arb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 any
);

  localparam int PW = $clog2(N);

  // Scan N positions starting at ptr; the first requester seen wins.
  always_comb begin : pick
    logic          found;
    logic [PW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/cdb_arb.sv
// Common data bus arbiter: grants one execution-unit result per cycle using
// round-robin with a starvation override, and registers it onto the bus.
module cdb_arb
  import cdb_arb_pkg::*;
#(
  parameter int N_REQ     = N_EXU,
  parameter int TAG_W     = CDB_TAG_W,
  parameter int ROB_PTR_W = CDB_ROB_PTR_W,
  parameter int MAX_WAIT  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*TAG_W-1:0]     req_tag,
  input  logic [N_REQ*ROB_PTR_W-1:0] req_rob_id,
  input  logic [N_REQ*32-1:0]        req_data,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [ROB_PTR_W-1:0]       cdb_rob_id,
  output logic [31:0]                cdb_data,
  output logic [N_REQ-1:0]           cdb_src
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0][WAIT_W-1:0] wait_q, wait_d;
  logic                         cdb_valid_q, cdb_valid_d;
  logic [N_REQ-1:0]             cdb_src_q, cdb_src_d;
  cdb_pkt_t                     cdb_pkt_q, cdb_pkt_d;

  logic [N_REQ-1:0] starved, st_gnt, rr_gnt, gnt;
  logic             st_any, rr_any;
  logic [PTR_W-1:0] win_idx;
  cdb_pkt_t         sel_pkt;

  // A requester is starved once it has been blocked MAX_WAIT cycles in a row.
  always_comb begin
    starved = '0;
    for (int i = 0; i < N_REQ; i++) begin
      starved[i] = req_valid[i] && (wait_q[i] == WAIT_W'(MAX_WAIT));
    end
  end

  // Starved search always starts at index 0 so the lowest starved unit wins.
  cdb_arb_rr_pick #(.N(N_REQ)) u_starve_pick (
    .req (starved),
    .ptr ('0),
    .gnt (st_gnt),
    .any (st_any)
  );

  cdb_arb_rr_pick #(.N(N_REQ)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt),
    .any (rr_any)
  );

  // Final grant: flush blocks everything, starvation overrides round-robin.
  always_comb begin
    gnt = '0;
    if (!flush) begin
      if (st_any)      gnt = st_gnt;
      else if (rr_any) gnt = rr_gnt;
    end
  end

  assign req_ready = gnt;

  // Encode the winner and select its payload from the packed request buses.
  always_comb begin
    win_idx = '0;
    sel_pkt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_idx        = PTR_W'(i);
        sel_pkt.tag    = req_tag[i*TAG_W +: TAG_W];
        sel_pkt.rob_id = req_rob_id[i*ROB_PTR_W +: ROB_PTR_W];
        sel_pkt.data   = req_data[i*32 +: 32];
      end
    end
  end

  // Next state: wait counters, round-robin pointer and the broadcast register.
  always_comb begin
    wait_d      = wait_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = |gnt;
    cdb_src_d   = gnt;
    cdb_pkt_d   = (|gnt) ? sel_pkt : cdb_pkt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (flush || !req_valid[i] || gnt[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WAIT_W'(MAX_WAIT)) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
    if (flush) begin
      rr_ptr_d = '0;
    end else if (|gnt) begin
      rr_ptr_d = PTR_W'((int'(win_idx) + 1) % N_REQ);
    end
  end

  // State registers; reset drops any pending broadcast immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      wait_q      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= '0;
      cdb_pkt_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wait_q      <= wait_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_pkt_q   <= cdb_pkt_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_src    = cdb_src_q;
  assign cdb_tag    = cdb_pkt_q.tag;
  assign cdb_rob_id = cdb_pkt_q.rob_id;
  assign cdb_data   = cdb_pkt_q.data;

endmodule

// File: tb/tb_cdb_arb.sv
// Bench for cdb_arb: per-cycle expected grants from the test plan, expected
// broadcasts queued at drive time and checked one cycle later.
module tb_cdb_arb;
  import cdb_arb_pkg::*;

  localparam int N  = 4;
  localparam int TW = 5;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*TW-1:0] req_tag;
  logic [N*RW-1:0] req_rob_id;
  logic [N*32-1:0] req_data;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [RW-1:0] cdb_rob_id;
  logic [31:0]   cdb_data;
  logic [N-1:0]  cdb_src;

  logic [TW-1:0] u_tag  [N];
  logic [RW-1:0] u_rob  [N];
  logic [31:0]   u_data [N];

  typedef struct packed {
    logic          v;
    logic [N-1:0]  src;
    logic [TW-1:0] tag;
    logic [RW-1:0] rob;
    logic [31:0]   data;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_tag    = '0;
    req_rob_id = '0;
    req_data   = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]    = u_tag[i];
      req_rob_id[i*RW +: RW] = u_rob[i];
      req_data[i*32 +: 32]   = u_data[i];
    end
  end

  cdb_arb dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_tag    (req_tag),
    .req_rob_id (req_rob_id),
    .req_data   (req_data),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_rob_id (cdb_rob_id),
    .cdb_data   (cdb_data),
    .cdb_src    (cdb_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_payload(input int i);
    u_tag[i]  = TW'($urandom);
    u_rob[i]  = RW'($urandom);
    u_data[i] = $urandom;
  endtask

  // Called at a negedge with inputs already driven; checks the grant, queues
  // the expected broadcast, then checks it just after the next rising edge.
  task automatic step(input string name, input logic [N-1:0] exp_gnt);
    exp_t e;
    exp_t o;
    #1;
    chk({name, ".ready"}, 32'(req_ready), 32'(exp_gnt));
    e     = last;
    e.v   = (exp_gnt != '0);
    e.src = exp_gnt;
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) begin
        e.tag  = u_tag[i];
        e.rob  = u_rob[i];
        e.data = u_data[i];
      end
    end
    sb.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk({name, ".valid"}, 32'(cdb_valid),  32'(o.v));
    chk({name, ".src"},   32'(cdb_src),    32'(o.src));
    chk({name, ".tag"},   32'(cdb_tag),    32'(o.tag));
    chk({name, ".rob"},   32'(cdb_rob_id), 32'(o.rob));
    chk({name, ".data"},  cdb_data,        o.data);
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) new_payload(i);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush     = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    last = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) new_payload(i);
    #1;
    chk("reset.valid", 32'(cdb_valid), 32'd0);
    chk("reset.src",   32'(cdb_src),   32'd0);
    chk("reset.tag",   32'(cdb_tag),   32'd0);
    chk("reset.rob",   32'(cdb_rob_id), 32'd0);
    chk("reset.data",  cdb_data,       32'd0);
    chk("reset.ready", 32'(req_ready), 32'd0);

    // Single requester
    do_reset();
    u_tag[EXU_ALU]  = 5'd5;
    u_rob[EXU_ALU]  = 4'd3;
    u_data[EXU_ALU] = 32'hDEADBEEF;
    req_valid = 4'b0001;
    step("single0", 4'b0001);
    req_valid = 4'b0000;
    step("single1", 4'b0000);

    // Round-robin with all units valid
    do_reset();
    req_valid = 4'b1111;
    step("rr0", 4'b0001);
    step("rr1", 4'b0010);
    step("rr2", 4'b0100);
    step("rr3", 4'b1000);
    step("rr4", 4'b0001);
    step("rr5", 4'b0010);

    // Starvation: pointer pinned on alu while mdu waits
    do_reset();
    force dut.rr_ptr_q = 2'd0;
    req_valid = 4'b0011;
    step("starve0", 4'b0001);
    step("starve1", 4'b0001);
    step("starve2", 4'b0001);
    step("starve3", 4'b0010);
    chk("starve.alu_wait", 32'(dut.wait_q[EXU_ALU]), 32'd1);
    step("starve4", 4'b0001);
    release dut.rr_ptr_q;
    req_valid = '0;

    // Two starved units; pointer favours jmp but mdu still goes first
    do_reset();
    force dut.rr_ptr_q = 2'd0;
    req_valid = 4'b1011;
    step("dual0", 4'b0001);
    step("dual1", 4'b0001);
    step("dual2", 4'b0001);
    force dut.rr_ptr_q = 2'd3;
    step("dual3", 4'b0010);
    step("dual4", 4'b1000);
    release dut.rr_ptr_q;
    req_valid = '0;

    // Flush
    do_reset();
    req_valid = 4'b1111;
    step("flush0", 4'b0001);
    flush = 1'b1;
    step("flush1", 4'b0000);
    flush = 1'b0;
    step("flush2", 4'b0001);
    step("flush3", 4'b0010);
    step("flush4", 4'b0100);
    step("flush5", 4'b1000);

    // Asynchronous reset between edges
    do_reset();
    req_valid = 4'b1111;
    step("areset0", 4'b0010 >> 1);
    #2;
    rst = 1'b1;
    #1;
    chk("areset.valid", 32'(cdb_valid), 32'd0);
    chk("areset.src",   32'(cdb_src),   32'd0);
    chk("areset.data",  cdb_data,       32'd0);
    sb.delete();
    last = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    step("areset1", 4'b0001);
    step("areset2", 4'b0010);
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
